// File: rtl/key_load_ctrl.sv
// key_load_ctrl: loads a 32-bit unlock key from a byte-wide key-store stream and
// applies it to the locked core only after a complete, validated load.
// Optional feature macro: KEY_CHECKSUM_EN adds a 5th XOR checksum beat, failure
// counting and a sticky lockout. Without it, four beats commit directly.
module key_load_ctrl #(
  parameter int unsigned MAX_FAIL  = 3,
  parameter int unsigned KEY_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  logic [7:0]  kin_data,
  input  logic        kin_valid,
  output logic        kin_ready,
  output logic [31:0] key_out,
  output logic        key_valid,
  output logic        out_gate_en,
  output logic        busy,
  output logic        error,
  output logic        locked_out,
  output logic [1:0]  fail_cnt
);

`ifdef KEY_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  localparam logic [1:0] MaxFail  = 2'(MAX_FAIL);
  localparam logic [1:0] LastBeat = 2'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StChk,
    StCommit,
    StArmed,
    StLockout
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] key_q, key_d;
  logic        key_valid_q, key_valid_d;
  logic [1:0]  fail_q, fail_d;
  logic        error_q, error_d;

  logic        accept;
  logic [7:0]  key_sum;
  logic [1:0]  fail_inc;

  assign kin_ready = (state_q == StLoad) || (state_q == StChk);
  assign accept    = kin_valid && kin_ready;
  assign key_sum   = shadow_q[7:0] ^ shadow_q[15:8] ^ shadow_q[23:16] ^ shadow_q[31:24];
  assign fail_inc  = fail_q + 2'd1;

  // Next-state and datapath updates; clear always wins over start and beats.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    beat_d      = beat_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    fail_d      = fail_q;
    error_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!clear && start) begin
          state_d  = StLoad;
          shadow_d = '0;
          beat_d   = '0;
        end
      end
      StArmed: begin
        if (clear) begin
          key_d       = '0;
          key_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (start) begin
          // Previous key stays applied until the new one commits.
          state_d  = StLoad;
          shadow_d = '0;
          beat_d   = '0;
        end
      end
      StLoad: begin
        if (clear) begin
          state_d = StIdle;
        end else if (accept) begin
          shadow_d[{beat_q, 3'b000} +: 8] = kin_data;
          beat_d = beat_q + 2'd1;
          if (beat_q == LastBeat) begin
            state_d = ChkEn ? StChk : StCommit;
          end
        end
      end
      StChk: begin
        if (ChkEn) begin
          if (clear) begin
            state_d = StIdle;
          end else if (accept) begin
            if (kin_data == key_sum) begin
              state_d = StCommit;
            end else begin
              error_d = 1'b1;
              fail_d  = fail_inc;
              if (fail_inc == MaxFail) begin
                state_d     = StLockout;
                key_d       = '0;
                key_valid_d = 1'b0;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end else begin
          state_d = StIdle;
        end
      end
      StCommit: begin
        key_d       = shadow_q;
        key_valid_d = 1'b1;
        fail_d      = '0;
        state_d     = StArmed;
      end
      StLockout: begin
        key_d       = '0;
        key_valid_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; async reset discards any partial load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shadow_q    <= '0;
      beat_q      <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      fail_q      <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      beat_q      <= beat_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      fail_q      <= fail_d;
      error_q     <= error_d;
    end
  end

  assign key_out     = key_q;
  assign key_valid   = key_valid_q;
  assign out_gate_en = key_valid_q;
  assign busy        = (state_q == StLoad) || (state_q == StChk) || (state_q == StCommit);
  assign error       = error_q;
  assign locked_out  = (state_q == StLockout);
  assign fail_cnt    = fail_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Self-checking bench for key_load_ctrl. Committed keys are checked through a
// scoreboard queue; the rest are directed checks. Honours KEY_CHECKSUM_EN.
module tb_key_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic [7:0]  kin_data;
  logic        kin_valid;
  logic        kin_ready;
  logic [31:0] key_out;
  logic        key_valid;
  logic        out_gate_en;
  logic        busy;
  logic        error;
  logic        locked_out;
  logic [1:0]  fail_cnt;

  int n_vec = 0;
  int n_err = 0;
  int err_pulses = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mon_key = '0;
  logic        mon_valid = 1'b0;

  key_load_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .kin_data   (kin_data),
    .kin_valid  (kin_valid),
    .kin_ready  (kin_ready),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .out_gate_en(out_gate_en),
    .busy       (busy),
    .error      (error),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every newly exposed committed key must match the oldest pushed key.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid && (!mon_valid || key_out != mon_key)) begin
        if (exp_q.size() == 0) check("sb_unexpected_commit", key_out, mon_key);
        else check("sb_key", key_out, exp_q.pop_front());
      end
      if (error) err_pulses++;
    end
    mon_key   = key_out;
    mon_valid = key_valid;
  end

  task automatic send_beat(input logic [7:0] b);
    int guard = 0;
    kin_data  = b;
    kin_valid = 1'b1;
    while (!kin_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_timeout", 32'(guard < 20), 32'd1);
    @(negedge clk);
    kin_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] key, input bit gaps, input bit good_sum);
    logic [7:0]  b;
    logic [7:0]  sum;
    logic [31:0] prev_key;
    logic        prev_valid;
    prev_key   = key_out;
    prev_valid = key_valid;
    if (good_sum) exp_q.push_back(key);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", kin_ready, 1);
    sum = 8'h00;
    for (int i = 0; i < 4; i++) begin
      b   = key[i*8 +: 8];
      sum = sum ^ b;
      send_beat(b);
      if (gaps && i < 3) begin
        kin_data = 8'hA5;
        if (i == 1) start = 1'b1;  // must be ignored mid-load
        @(negedge clk);
        start = 1'b0;
      end
    end
`ifdef KEY_CHECKSUM_EN
    send_beat(good_sum ? sum : 8'h00);
`endif
    if (good_sum) begin
      check("commit_busy", busy, 1);
      check("commit_ready_low", kin_ready, 0);
      check("commit_valid_hold", key_valid, prev_valid);
      check("commit_key_hold", key_out, prev_valid ? prev_key : 32'h0);
      @(negedge clk);
      check("armed_valid", key_valid, 1);
      check("armed_gate", out_gate_en, 1);
      check("armed_key", key_out, key);
      check("armed_fail_cnt", fail_cnt, 0);
      check("armed_busy", busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; kin_data = 8'h00; kin_valid = 1'b0;
    #12;
    check("rst_key", key_out, 0);
    check("rst_valid", key_valid, 0);
    check("rst_gate", out_gate_en, 0);
    check("rst_ready", kin_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_locked", locked_out, 0);
    check("rst_fail", fail_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_load(32'hDEADBEEF, 1'b0, 1'b1);

    // Partial reload from ARMED aborted by clear keeps the old key.
    start = 1'b1; @(negedge clk); start = 1'b0;
    send_beat(8'h11);
    send_beat(8'h22);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    check("abort_key", key_out, 32'hDEADBEEF);
    check("abort_valid", key_valid, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", kin_ready, 0);
    check("abort_fail", fail_cnt, 0);

    do_load(32'h04030201, 1'b0, 1'b1);

    // clear beats start in ARMED.
    clear = 1'b1; start = 1'b1; @(negedge clk); clear = 1'b0; start = 1'b0;
    check("clr_key", key_out, 0);
    check("clr_valid", key_valid, 0);
    check("clr_gate", out_gate_en, 0);
    check("clr_busy", busy, 0);
    @(negedge clk);
    check("clr_ready", kin_ready, 0);

    // Gapped load with a stray start must match the gap-free result.
    do_load(32'hDEADBEEF, 1'b1, 1'b1);

`ifdef KEY_CHECKSUM_EN
    for (int k = 1; k <= 3; k++) begin
      do_load(32'h12345678, 1'b0, 1'b0);
      check("bad_error", error, 1);
      check("bad_fail_cnt", fail_cnt, 32'(k));
      check("bad_locked", locked_out, 32'(k == 3));
      @(negedge clk);
      check("bad_error_once", error, 0);
    end
    check("lock_key", key_out, 0);
    check("lock_valid", key_valid, 0);
    check("lock_ready", kin_ready, 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("lock_start_ignored", kin_ready, 0);
    check("lock_sticky", locked_out, 1);
`endif

    // Asynchronous reset in the middle of a load.
    start = 1'b1; @(negedge clk); start = 1'b0;
    kin_data = 8'h77; kin_valid = 1'b1; @(negedge clk); kin_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_key", key_out, 0);
    check("arst_valid", key_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", kin_ready, 0);
    check("arst_locked", locked_out, 0);
    check("arst_fail", fail_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", kin_ready, 0);

`ifdef KEY_CHECKSUM_EN
    check("error_pulses", err_pulses, 3);
`else
    check("error_never", err_pulses, 0);
`endif
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
